serial_rx_control: RTL
======================

Name: serial_rx_control

Overview:
- Receive-side engine of the EMC08 serial port (8051-style SCON modes 0–3).
- Samples RXD (P3.0 input), assembles each frame and applies the SM2/RI load rules.
- Writes the receive SBUF and RB8, and pulses the RI set request to the SFR logic.
- Drives the "receiving" indication that the serial output logic uses to generate the mode 0 shift clock on P3.1.

Parameters:
- DATA_W, 8, number of data bits per frame (LSB first).
- OVS, 16, baud-tick oversampling factor for modes 1–3.
- SAMPLE_MID, 7, first of three consecutive majority-vote sample points (7, 8, 9).

Ports:
- serial_clock_internal_i, in, 1, core clock.
- serial_reset_internal_i_b, in, 1, asynchronous active-low reset.
- serial_br_internal_i, in, 1, one-cycle tick: bit tick in mode 0, OVS× bit-rate tick in modes 1–3.
- serial_p3_0_i, in, 1, raw RXD pin (asynchronous).
- serial_scon7_sm0_internal_i, in, 1, SM0.
- serial_scon6_sm1_internal_i, in, 1, SM1.
- serial_scon5_sm2_internal_i, in, 1, SM2 multiprocessor enable.
- serial_scon4_ren_internal_i, in, 1, receive enable.
- serial_scon0_ri_internal_i, in, 1, current RI flag.
- serial_sbuf_rx_o, out, 8, received data buffer.
- serial_rb8_o, out, 1, 9th bit (modes 2/3) or stop bit (mode 1).
- serial_set_ri_o, out, 1, one-cycle RI set request.
- serial_load_sbuf_o, out, 1, one-cycle pulse when SBUF/RB8 are updated.
- serial_receive_o, out, 1, high while a frame is in progress.

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is asynchronous, active-low.
  - Reset values: all outputs 0; FSM = IDLE; RXD synchroniser = 1.
- RXD path:
  - RXD passes through a 2-flop synchroniser (2-cycle latency).
  - A falling edge is detected on the synchronised value.
- Mode 0 (SM0 = 0, SM1 = 0):
  - Start condition: REN = 1 and RI = 0 while in IDLE. Go to M0_SHIFT and raise serial_receive_o the next cycle.
  - Each br tick shifts the synchronised RXD into bit [7] (right shift).
  - After 8 ticks go to LOAD.
- Modes 1–3 (asynchronous modes):
  - Start condition: REN = 1 and a falling edge on synchronised RXD. Go to START and clear the tick counter.
  - Every br tick increments a 4-bit tick counter, which wraps 15 → 0.
  - Bit value = majority of the samples at counts 7, 8, 9.
  - At wrap, the bit is complete.
- Asynchronous-mode FSM:
  - START:
    - If the voted start bit = 1 (false start), return to IDLE with no outputs.
    - Otherwise go to DATA.
  - DATA: 8 bits, LSB first, then:
    - mode 1 → STOP;
    - modes 2/3 → NINTH.
  - NINTH: capture bit 9, go to STOP.
  - STOP: capture the stop bit, go to LOAD.
- LOAD (single cycle, all modes):
  - Load only if RI = 0 and (SM2 = 0 or B = 1), where:
    - modes 2/3: B = bit 9;
    - mode 1: B = stop bit;
    - mode 0: load requires only RI = 0.
  - On load: SBUF and RB8 update, serial_load_sbuf_o and serial_set_ri_o pulse high together for 1 cycle. RB8 is unchanged in mode 0.
  - If the rule fails, the frame is discarded and there are no pulses.
  - Always return to IDLE. serial_receive_o falls in the same cycle.
- Boundary conditions:
  - REN falling mid-frame: abort to IDLE at the next clock, no load.
  - SM0/SM1 change mid-frame: abort to IDLE.
  - RI is evaluated in the LOAD cycle. If RI is set by software during the frame, the frame is discarded.
  - br tick in the same cycle as the falling edge: that tick is not counted; counting starts with the following tick.
  - Async reset mid-frame: immediate return to reset values; the partial frame is lost.

Optional Feature:
- Macro: SERIAL_RX_FRAME_ERR_EN.
- With the macro defined:
  - Adds input serial_fe_clr_i (1 bit) and output serial_fe_o (1 bit, reset 0).
  - In modes 1–3, a voted stop bit = 0 sets serial_fe_o in the LOAD cycle, regardless of the load rule.
  - serial_fe_o is sticky until serial_fe_clr_i = 1.
  - If set and clear occur in the same cycle, set wins.
- Without the macro: neither port exists, and the stop bit is used only for RB8 in mode 1.

Decomposition:
- Package serial_pkg holds:
  - FSM state encoding: IDLE, M0_SHIFT, START, DATA, NINTH, STOP, LOAD;
  - mode constants MODE0..MODE3;
  - SAMPLE_MID and OVS defaults.
- One sub-module, serial_rx_sampler:
  - 2-flop synchroniser, falling-edge detector and tick counter;
  - 3-sample majority vote;
  - outputs bit_done and bit_val.

Test Plan:
- Mode 1, REN = 1, SM2 = 0, RI = 0, RXD frame 0xA5 with stop = 1 → SBUF = 0xA5, RB8 = 1, set_ri and load_sbuf pulse 1 cycle after the stop bit completes.
- Mode 2, SM2 = 1, frame 0x3C with bit 9 = 0 → no load, SBUF keeps its old value. Repeat with bit 9 = 1 → SBUF = 0x3C, RB8 = 1.
- Mode 3, false start (RXD low for 4 ticks only) → return to IDLE, serial_receive_o deasserts, no pulses.
- Mode 0, REN = 1, RI = 0, RXD bits 1,0,1,1,0,0,1,0 on 8 ticks → SBUF = 0x4D, serial_receive_o high for the 8 ticks.
- Mode 1 with RI = 1 at LOAD → frame discarded. Also: REN dropped at data bit 4 → IDLE, no load. Also: reset asserted mid-frame → all outputs 0 immediately.
- SERIAL_RX_FRAME_ERR_EN build, mode 1 frame with stop = 0 → serial_fe_o = 1 and held. serial_fe_clr_i pulse → serial_fe_o = 0.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial port receive engine.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    M0_SHIFT,
    START,
    DATA,
    NINTH,
    STOP,
    LOAD
  } rx_state_t;

  // {SM0, SM1}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int DATA_W_DEF     = 8;
  localparam int OVS_DEF        = 16;
  localparam int SAMPLE_MID_DEF = 7;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/serial_rx_sampler.sv
// RXD synchroniser, falling-edge detector, oversampling tick counter and
// three-point majority vote for the asynchronous serial modes.
module serial_rx_sampler
  import serial_pkg::*;
#(
  parameter int OVS        = OVS_DEF,
  parameter int SAMPLE_MID = SAMPLE_MID_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic br,
  input  logic rxd_pin,
  input  logic run,
  output logic rxd_s,
  output logic fall,
  output logic bit_done,
  output logic bit_val
);

  localparam int CNT_W = $clog2(OVS);

  logic             sync1;
  logic             sync2;
  logic             rxd_d;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       smp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      sync1 <= rxd_pin;
      sync2 <= sync1;
      rxd_d <= sync2;
    end
  end

  // Counter is held at zero outside a frame, so a tick coinciding with the
  // start edge is never counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (br) begin
      cnt <= (cnt == CNT_W'(OVS - 1)) ? '0 : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (run && br) begin
      if (cnt == CNT_W'(SAMPLE_MID))     smp[0] <= sync2;
      if (cnt == CNT_W'(SAMPLE_MID + 1)) smp[1] <= sync2;
      if (cnt == CNT_W'(SAMPLE_MID + 2)) smp[2] <= sync2;
    end
  end

  assign rxd_s    = sync2;
  assign fall     = rxd_d & ~sync2;
  assign bit_done = run & br & (cnt == CNT_W'(OVS - 1));
  assign bit_val  = maj3(smp[0], smp[1], smp[2]);

endmodule

// File: rtl/serial_rx_control.sv
// Receive engine for 8051-style serial modes 0-3: frame assembly, SM2/RI load
// rule, SBUF/RB8 update. Optional sticky frame-error flag: SERIAL_RX_FRAME_ERR_EN.
module serial_rx_control
  import serial_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int OVS        = OVS_DEF,
  parameter int SAMPLE_MID = SAMPLE_MID_DEF
) (
  input  logic              serial_clock_internal_i,
  input  logic              serial_reset_internal_i_b,
  input  logic              serial_br_internal_i,
  input  logic              serial_p3_0_i,
  input  logic              serial_scon7_sm0_internal_i,
  input  logic              serial_scon6_sm1_internal_i,
  input  logic              serial_scon5_sm2_internal_i,
  input  logic              serial_scon4_ren_internal_i,
  input  logic              serial_scon0_ri_internal_i,
  output logic [DATA_W-1:0] serial_sbuf_rx_o,
  output logic              serial_rb8_o,
  output logic              serial_set_ri_o,
  output logic              serial_load_sbuf_o,
  output logic              serial_receive_o
`ifdef SERIAL_RX_FRAME_ERR_EN
  ,
  input  logic              serial_fe_clr_i,
  output logic              serial_fe_o
`endif
);

  localparam int BC_W = $clog2(DATA_W) + 1;

  logic              clk;
  logic              rst_n;
  logic [1:0]        mode;
  logic [1:0]        mode_q;
  rx_state_t         state;
  rx_state_t         state_nxt;
  logic [BC_W-1:0]   bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              b9;
  logic              stop_bit;
  logic              run;
  logic              rxd_s;
  logic              fall;
  logic              bit_done;
  logic              bit_val;
  logic              abort;
  logic              last_bit;
  logic              load_ok;
  logic              do_load;

  assign clk   = serial_clock_internal_i;
  assign rst_n = serial_reset_internal_i_b;
  assign mode  = {serial_scon7_sm0_internal_i, serial_scon6_sm1_internal_i};

  assign run = (state == START) || (state == DATA) || (state == NINTH) || (state == STOP);

  serial_rx_sampler #(
    .OVS        (OVS),
    .SAMPLE_MID (SAMPLE_MID)
  ) u_sampler (
    .clk      (clk),
    .rst_n    (rst_n),
    .br       (serial_br_internal_i),
    .rxd_pin  (serial_p3_0_i),
    .run      (run),
    .rxd_s    (rxd_s),
    .fall     (fall),
    .bit_done (bit_done),
    .bit_val  (bit_val)
  );

  // LOAD is the frame's final cycle and is never cut short.
  assign abort = (state != IDLE) && (state != LOAD) &&
                 (!serial_scon4_ren_internal_i || (mode != mode_q));

  assign last_bit = (bit_cnt == BC_W'(DATA_W - 1));

  assign load_ok = !serial_scon0_ri_internal_i &&
                   ((mode_q == MODE0) || !serial_scon5_sm2_internal_i ||
                    ((mode_q == MODE1) ? stop_bit : b9));
  assign do_load = (state == LOAD) && load_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (serial_scon4_ren_internal_i) begin
            if (mode == MODE0) begin
              if (!serial_scon0_ri_internal_i) state_nxt = M0_SHIFT;
            end else if (fall) begin
              state_nxt = START;
            end
          end
        end
        M0_SHIFT: if (serial_br_internal_i && last_bit) state_nxt = LOAD;
        START:    if (bit_done) state_nxt = bit_val ? IDLE : DATA;
        DATA: begin
          if (bit_done && last_bit) state_nxt = (mode_q == MODE1) ? STOP : NINTH;
        end
        NINTH:    if (bit_done) state_nxt = STOP;
        STOP:     if (bit_done) state_nxt = LOAD;
        LOAD:     state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE0;
      bit_cnt <= '0;
    end else begin
      if (state == IDLE) mode_q <= mode;
      if ((state == IDLE) || (state == START)) begin
        bit_cnt <= '0;
      end else if (((state == M0_SHIFT) && serial_br_internal_i) ||
                   ((state == DATA) && bit_done)) begin
        bit_cnt <= bit_cnt + BC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state == M0_SHIFT) && serial_br_internal_i) shreg <= {rxd_s, shreg[DATA_W-1:1]};
    if ((state == DATA) && bit_done)                 shreg <= {bit_val, shreg[DATA_W-1:1]};
    if ((state == NINTH) && bit_done)                b9 <= bit_val;
    if ((state == STOP) && bit_done)                 stop_bit <= bit_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      serial_sbuf_rx_o <= '0;
      serial_rb8_o     <= 1'b0;
    end else if (do_load) begin
      serial_sbuf_rx_o <= shreg;
      if (mode_q == MODE1)      serial_rb8_o <= stop_bit;
      else if (mode_q != MODE0) serial_rb8_o <= b9;
    end
  end

  assign serial_set_ri_o    = do_load;
  assign serial_load_sbuf_o = do_load;
  assign serial_receive_o   = run || (state == M0_SHIFT);

`ifdef SERIAL_RX_FRAME_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      serial_fe_o <= 1'b0;
    end else if ((state == LOAD) && (mode_q != MODE0) && !stop_bit) begin
      serial_fe_o <= 1'b1;
    end else if (serial_fe_clr_i) begin
      serial_fe_o <= 1'b0;
    end
  end
`endif

endmodule
